// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL utilities.
// The round-robin arbiter FSM state lives here.
package rggen_rtl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_rr_arbiter_state_e;

endpackage

// File: rtl/rggen_onehot.sv
// Onehot-to-binary utility interface: binary is the OR of the indices
// of all set bits, which equals the index of the single set bit of a one-hot vector.
interface rggen_onehot #(
  parameter  int N = 2,
  localparam int W = (N >= 2) ? $clog2(N) : 1
) ();

  logic [N-1:0] onehot;
  logic [W-1:0] binary;

  always_comb begin
    binary = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) begin
        binary = binary | W'(i);
      end
    end
  end

endinterface

// File: rtl/rggen_rr_select.sv
// Combinational round-robin pick: first set request scanning from ptr
// upward with wrap-around, done as a masked then unmasked lowest-bit pick.
module rggen_rr_select #(
  parameter  int N            = 2,
  localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            i_request,
  input  logic [BINARY_WIDTH-1:0] i_ptr,
  output logic [N-1:0]            o_select
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] masked_pick;
  logic [N-1:0] plain_pick;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (BINARY_WIDTH'(i) >= i_ptr);
    end
    masked      = i_request & mask;
    // x & -x isolates the lowest set bit
    masked_pick = masked & (~masked + N'(1));
    plain_pick  = i_request & (~i_request + N'(1));
    o_select    = (|masked) ? masked_pick : plain_pick;
  end

endmodule

// File: rtl/rggen_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until i_free.
// Optional RGGEN_RR_ARBITER_FAST_SWITCH_EN: hand over to the next requester on the i_free edge.
module rggen_rr_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter  int N            = 2,
  localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N-1:0]            i_request,
  input  logic                    i_free,
  output logic [N-1:0]            o_grant,
  output logic [BINARY_WIDTH-1:0] o_grant_index,
  output logic                    o_busy
);

  rggen_rr_arbiter_state_e state_q, state_d;
  logic [N-1:0]            grant_q, grant_d;
  logic [BINARY_WIDTH-1:0] index_q, index_d;
  logic [BINARY_WIDTH-1:0] ptr_q, ptr_d;
  logic [BINARY_WIDTH-1:0] ptr_next;
  logic [BINARY_WIDTH-1:0] sel_ptr;
  logic [N-1:0]            select;
  logic                    release_grant;

  // The select sees the post-release pointer so a same-edge handover keeps the fairness order
  rggen_rr_select #(
    .N (N)
  ) u_select (
    .i_request (i_request),
    .i_ptr     (sel_ptr),
    .o_select  (select)
  );

  rggen_onehot #(
    .N (N)
  ) u_onehot ();

  assign u_onehot.onehot = grant_d;
  assign index_d         = u_onehot.binary;

  always_comb begin
    release_grant = (state_q == BUSY) && i_free;
    ptr_next      = (index_q == BINARY_WIDTH'(N - 1)) ? '0 : index_q + BINARY_WIDTH'(1);
    sel_ptr       = release_grant ? ptr_next : ptr_q;

    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        if (|i_request) begin
          grant_d = select;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_free) begin
          ptr_d = ptr_next;
`ifdef RGGEN_RR_ARBITER_FAST_SWITCH_EN
          if (|i_request) begin
            grant_d = select;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
`else
          grant_d = '0;
          state_d = IDLE;
`endif
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_index = index_q;
  assign o_busy        = |grant_q;

endmodule

// File: doc/rggen_rr_arbiter.md
# rggen_rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. It produces a registered one-hot grant plus its binary index for mux selects and bus IDs. The grant is held until the current owner signals completion. It sits between requester-side register/bus masters and a shared port such as a bus bridge or a shared register-file access port.

## Interface
- `N`, default 2: number of requesters; N >= 1.
- `BINARY_WIDTH`, localparam: `(N >= 2) ? $clog2(N) : 1`.
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: one clock; reset is synchronous and active-high.
- `i_request`, input, N: level request per requester.
- `i_free`, input, 1: single-cycle pulse from the current owner; its transaction is complete.
- `o_grant`, output, N: registered one-hot grant; all-zero when idle.
- `o_grant_index`, output, BINARY_WIDTH: binary index of the set bit of `o_grant`; 0 when idle.
- `o_busy`, output, 1: a grant is active (`|o_grant`).

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one grant held.
- Priority pointer `ptr` (BINARY_WIDTH bits) marks the highest-priority requester for the next decision.
- Selection scans `ptr, ptr+1, …, N-1, 0, …, ptr-1` and picks the first set `i_request` bit.
  - Implemented as a masked priority pick: requests at index >= ptr first, then the unmasked vector.
- IDLE + any request:
  - Register the selected one-hot into `o_grant`; go to BUSY.
  - `o_grant_index` is derived from `o_grant` via onehot-to-binary (OR of index bits) and is registered alongside it.
- IDLE + no request: stay in IDLE. `i_free` in IDLE is ignored.
- BUSY:
  - Grant is frozen regardless of `i_request` changes, including the owner deasserting its request.
  - On `i_free`: `ptr <= (o_grant_index == N-1) ? 0 : o_grant_index + 1`, then proceed as described under Configuration.
- N == 1: `ptr` is constant 0, `o_grant_index` is constant 0, and the grant is bit 0 only.
- Reset:
  - `o_grant = 0`, `o_grant_index = 0`, `o_busy = 0`, `ptr = 0`, state IDLE.
  - Reset asserted while BUSY drops the grant at the next edge, with no `i_free` needed.
- Non-one-hot grant is impossible by construction. Verification must assert `$onehot0(o_grant)`.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge k in IDLE produces a grant visible after edge k.
- Grant release: `i_free` sampled at edge k clears (or switches) the grant after edge k.
- Simultaneous requests are resolved by the pointer only. No starvation: each requester waits at most N-1 grants.
- A request that rises in the same cycle as `i_free` is eligible for the next selection.

## Configuration
- `RGGEN_RR_ARBITER_FAST_SWITCH_EN`
  - Defined: on `i_free` with any request pending, select the next owner using the updated pointer and load the new grant at the same edge. The state stays BUSY and there is no idle bubble (zero-cycle turnaround).
  - Not defined: `i_free` always returns to IDLE with grant 0 for at least one cycle. The next grant appears one cycle later (one-cycle bubble).
- In both modes the pointer update and the fairness order are identical.

## Structure
- Shared package `rggen_rtl_pkg`: state enum `rggen_rr_arbiter_state_e` (IDLE, BUSY).
- Onehot-to-binary conversion reuses the existing `rggen_onehot` utility interface instantiated with parameter N.
- One sub-module: `rggen_rr_select`.
  - Purely combinational.
  - Inputs: request vector and `ptr`.
  - Output: one-hot selection using the masked/unmasked priority scheme.
- The top module holds the FSM, the pointer and the grant registers.

## Test plan
- Reset: assert `i_rst` for 2 cycles with `i_request=4'b1111` (N=4) → `o_grant=0`, `o_grant_index=0`, `o_busy=0` throughout. First grant after release is `4'b0001`.
- Rotation: N=4, `i_request=4'b1111` held, pulse `i_free` after each grant → grants 0001, 0010, 0100, 1000, 0001; indices 0,1,2,3,0. Bubble present only without FAST_SWITCH.
- Skip and wrap: `ptr=2` (after granting 1), `i_request=4'b0011` → grant `4'b0001`, index 0, then `ptr=1`.
- Hold: owner 2 drops `i_request` mid-BUSY, no `i_free` → `o_grant` stays `4'b0100` for 10 cycles. Then `i_free` → grant clears or switches.
- Simultaneous events: `i_free` in the same cycle as a new `i_request[3]` rise with `ptr` moving to 3 → requester 3 is granted next (same edge with FAST_SWITCH, else after 1 bubble cycle).
- Reset mid-operation: `i_rst` pulsed while `o_grant=4'b1000` → next cycle `o_grant=0`, `ptr=0`. The following grant favors requester 0.
